phys_reg_free_list: RTL and testbench
=====================================

PHYS_REG_FREE_LIST -- requirements
Module: phys_reg_free_list

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: rst  input  1  synchronous active-high reset, sampled on clk rising edge.
REQ-003 SHALL have port: alloc_req  input  1  rename stage requests one physical tag this cycle.
REQ-004 SHALL have port: alloc_valid  output  1  a free tag is available (list not empty).
REQ-005 SHALL have port: alloc_tag  output  6  physical tag at list head, valid when alloc_valid.
REQ-006 SHALL have port: free_valid  input  1  commit stage releases one physical tag this cycle.
REQ-007 SHALL have port: free_tag  input  6  physical tag being released.
REQ-008 SHALL have port: ckpt_save  input  1  snapshot head pointer at a predicted branch.
REQ-009 SHALL have port: recover  input  1  misprediction flush; restore head from snapshot.
REQ-010 SHALL have port: free_count  output  7  number of tags currently in list, 0..64.
REQ-011 SHALL have port: empty  output  1  free_count == 0.
REQ-012 SHALL have port: full  output  1  free_count == 64.
REQ-013 SHALL have port: overflow_err  output  1  sticky; set on free while full.

Function
REQ-014 SHALL store tags in a 64-entry circular buffer, 6-bit entries, with head and tail held as 7-bit pointers (6-bit index plus wrap bit).
REQ-015 SHALL compute free_count = tail - head, modulo 128, in 7 bits; empty and full SHALL derive from it.
REQ-016 SHALL drive alloc_tag combinationally from mem[head[5:0]] (first-word fall-through), zero added latency.
REQ-017 SHALL drive alloc_valid = !empty, independent of alloc_req.
REQ-018 SHALL grant an allocation when alloc_req && alloc_valid && !recover; head SHALL increment by 1 at the next edge.
REQ-019 SHALL ignore alloc_req when empty; head unchanged, no error flagged.
REQ-020 SHALL accept a free when free_valid && !full: write free_tag to mem[tail[5:0]], tail increments by 1.
REQ-021 SHALL ignore free_valid when full, leave tail and memory unchanged, and set overflow_err to 1 until reset.
REQ-022 SHALL process a grant and a free in the same cycle independently; free_count unchanged when both occur.
REQ-023 SHALL NOT bypass a same-cycle free_tag to alloc_tag; a freed tag is allocatable from the following cycle.
REQ-024 SHALL on ckpt_save load the checkpoint register with the post-update head (head + 1 if a grant occurs that cycle, else head).
REQ-025 SHALL on recover set head to the checkpoint value; any alloc_req that cycle SHALL NOT be granted.
REQ-026 SHALL still accept a free coinciding with recover; tail updates normally.
REQ-027 SHALL give recover priority over a coincident ckpt_save; checkpoint SHALL then hold the restored head value.
REQ-028 SHALL allow head and tail to wrap from index 63 to 0, toggling the wrap bit.
REQ-029 SHALL leave the checkpoint unchanged if recover is asserted with no prior ckpt_save since reset; head then returns to its reset value 0.

Reset
REQ-030 SHALL on rst load mem[i] = 32 + i for i = 0..31, with mem[32..63] don't-care.
REQ-031 SHALL on rst set head = 0, tail = 32, checkpoint = 0, and overflow_err = 0.
REQ-032 SHALL present the following outputs in the first cycle after reset: free_count = 32, alloc_valid = 1, alloc_tag = 32, empty = 0, full = 0.
REQ-033 SHALL give rst priority over every other input; asserting rst mid-operation discards all pending state.

Verification
REQ-034 SHALL test reset then drain: hold alloc_req for 32 cycles -> tags 32..63 granted in order, then empty = 1, alloc_valid = 0, free_count = 0.
REQ-035 SHALL test free while empty: from empty, assert free_valid with free_tag = 5 and alloc_req in the same cycle -> no grant that cycle; next cycle alloc_tag = 5 and free_count = 1.
REQ-036 SHALL test fill to full: after reset, free 32 tags -> full = 1 and free_count = 64; a 33rd free -> overflow_err = 1 and tail unchanged.
REQ-037 SHALL test checkpoint and recover: after reset, allocate 32 and 33, assert ckpt_save while granting 34, allocate 35 and 36, then recover with alloc_req = 1 -> no grant, next alloc_tag = 35, free_count = 29.
REQ-038 SHALL test wrap-around: allocate and free continuously for 200 cycles with alloc and free in the same cycle -> free_count stays constant, pointers wrap, and the tag sequence matches the FIFO order.
REQ-039 SHALL test reset mid-operation: assert rst while alloc_req, free_valid and recover are all active -> next cycle state equals the REQ-032 values exactly.

Source files
------------

// File: rtl/phys_reg_free_list.sv
// Physical register free list: 64-entry circular FIFO of free tags with
// first-word fall-through allocation and a single head checkpoint for branch recovery.
module phys_reg_free_list (
  input  logic       clk,
  input  logic       rst,
  input  logic       alloc_req,
  output logic       alloc_valid,
  output logic [5:0] alloc_tag,
  input  logic       free_valid,
  input  logic [5:0] free_tag,
  input  logic       ckpt_save,
  input  logic       recover,
  output logic [6:0] free_count,
  output logic       empty,
  output logic       full,
  output logic       overflow_err
);

  logic [5:0] mem_q [64];
  logic [6:0] head_q, head_d;
  logic [6:0] tail_q, tail_d;
  logic [6:0] ckpt_q, ckpt_d;
  logic       overflow_q, overflow_d;
  logic       grant;
  logic       free_ok;

  assign free_count   = tail_q - head_q;
  assign empty        = (free_count == 7'd0);
  assign full         = (free_count == 7'd64);
  assign alloc_valid  = !empty;
  assign alloc_tag    = mem_q[head_q[5:0]];
  assign overflow_err = overflow_q;

  assign grant   = alloc_req && alloc_valid && !recover;
  assign free_ok = free_valid && !full;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    ckpt_d     = ckpt_q;
    overflow_d = overflow_q;
    if (recover) begin
      head_d = ckpt_q;
    end else if (grant) begin
      head_d = head_q + 7'd1;
    end
    // On recover head_d is the checkpoint itself, so a coincident save keeps it.
    if (ckpt_save) begin
      ckpt_d = head_d;
    end
    if (free_ok) begin
      tail_d = tail_q + 7'd1;
    end
    if (free_valid && full) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= 7'd0;
      tail_q     <= 7'd32;
      ckpt_q     <= 7'd0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      ckpt_q     <= ckpt_d;
      overflow_q <= overflow_d;
    end
  end

  // Upper half of the array is left uninitialised at reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        mem_q[i] <= 6'(32 + i);
      end
    end else if (free_ok) begin
      mem_q[tail_q[5:0]] <= free_tag;
    end
  end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Randomised and directed bench for phys_reg_free_list against a queue-based model
// of the free tags and of the tags handed out since the last checkpoint.
module tb_phys_reg_free_list;

  logic       clk;
  logic       rst;
  logic       alloc_req;
  logic       alloc_valid;
  logic [5:0] alloc_tag;
  logic       free_valid;
  logic [5:0] free_tag;
  logic       ckpt_save;
  logic       recover;
  logic [6:0] free_count;
  logic       empty;
  logic       full;
  logic       overflow_err;

  phys_reg_free_list dut (
    .clk          (clk),
    .rst          (rst),
    .alloc_req    (alloc_req),
    .alloc_valid  (alloc_valid),
    .alloc_tag    (alloc_tag),
    .free_valid   (free_valid),
    .free_tag     (free_tag),
    .ckpt_save    (ckpt_save),
    .recover      (recover),
    .free_count   (free_count),
    .empty        (empty),
    .full         (full),
    .overflow_err (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: fl holds free tags in allocation order; since holds tags granted
  // after the current checkpoint, which a recover puts back at the front.
  logic [5:0] fl[$];
  logic [5:0] since[$];
  bit         m_ovf;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic model_reset();
    fl.delete();
    since.delete();
    for (int i = 0; i < 32; i++) fl.push_back(6'(32 + i));
    m_ovf = 1'b0;
  endtask

  task automatic check_outputs();
    check("alloc_valid", int'(alloc_valid), int'(fl.size() != 0));
    if (fl.size() != 0) check("alloc_tag", int'(alloc_tag), int'(fl[0]));
    check("free_count", int'(free_count), fl.size());
    check("empty", int'(empty), int'(fl.size() == 0));
    check("full", int'(full), int'(fl.size() == 64));
    check("overflow_err", int'(overflow_err), int'(m_ovf));
  endtask

  // Called at the negedge: check, drive one cycle of inputs, advance model.
  task automatic step(input bit a, input bit f, input logic [5:0] ft,
                      input bit cs, input bit rc);
    bit grant;
    bit accept;
    check_outputs();
    alloc_req  = a;
    free_valid = f;
    free_tag   = ft;
    ckpt_save  = cs;
    recover    = rc;
    grant  = a && (fl.size() != 0) && !rc;
    accept = f && (fl.size() != 64);
    if (f && !accept) m_ovf = 1'b1;
    if (grant) since.push_back(fl.pop_front());
    if (rc) begin
      fl = {since, fl};
      since.delete();
    end else if (cs) begin
      since.delete();
    end
    if (accept) fl.push_back(ft);
    @(posedge clk);
    @(negedge clk);
    alloc_req  = 1'b0;
    free_valid = 1'b0;
    ckpt_save  = 1'b0;
    recover    = 1'b0;
  endtask

  task automatic do_reset(input bit a, input bit f, input bit rc);
    rst        = 1'b1;
    alloc_req  = a;
    free_valid = f;
    free_tag   = 6'd7;
    recover    = rc;
    ckpt_save  = rc;
    @(posedge clk);
    @(negedge clk);
    rst        = 1'b0;
    alloc_req  = 1'b0;
    free_valid = 1'b0;
    recover    = 1'b0;
    ckpt_save  = 1'b0;
    model_reset();
    check("rst_free_count", int'(free_count), 32);
    check("rst_alloc_valid", int'(alloc_valid), 1);
    check("rst_alloc_tag", int'(alloc_tag), 32);
    check("rst_empty", int'(empty), 0);
    check("rst_full", int'(full), 0);
    check("rst_overflow", int'(overflow_err), 0);
  endtask

  initial begin
    rst = 1'b1; alloc_req = 1'b0; free_valid = 1'b0; free_tag = 6'd0;
    ckpt_save = 1'b0; recover = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset(1'b0, 1'b0, 1'b0);

    // Drain: tags 32..63 in order, then empty.
    for (int i = 0; i < 32; i++) begin
      check("drain_tag", int'(alloc_tag), 32 + i);
      step(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
    end
    check("drained_empty", int'(empty), 1);
    check("drained_valid", int'(alloc_valid), 0);
    check("drained_count", int'(free_count), 0);
    step(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);

    // Free while empty with a coincident request: no bypass.
    step(1'b1, 1'b1, 6'd5, 1'b0, 1'b0);
    check("nobypass_tag", int'(alloc_tag), 5);
    check("nobypass_count", int'(free_count), 1);
    step(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);

    // Fill to full, then overflow.
    do_reset(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 6'($urandom_range(0, 63)), 1'b0, 1'b0);
    check("fill_full", int'(full), 1);
    check("fill_count", int'(free_count), 64);
    step(1'b0, 1'b1, 6'd9, 1'b0, 1'b0);
    check("ovf_set", int'(overflow_err), 1);
    check("ovf_count", int'(free_count), 64);
    // Drain everything to confirm the rejected free left memory alone.
    for (int i = 0; i < 65; i++) step(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);

    // Checkpoint and recover.
    do_reset(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 6'd0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 6'd0, 1'b0, 1'b1);
    check("recover_tag", int'(alloc_tag), 35);
    check("recover_count", int'(free_count), 29);
    step(1'b0, 1'b0, 6'd0, 1'b0, 1'b1);

    // Recover with no checkpoint since reset returns head to 0.
    do_reset(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 6'd11, 1'b0, 1'b1);
    check("nockpt_tag", int'(alloc_tag), 32);
    check("nockpt_count", int'(free_count), 33);

    // Wrap-around: simultaneous alloc and free for 200 cycles.
    do_reset(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 200; i++) begin
      step(1'b1, 1'b1, 6'($urandom_range(0, 63)), 1'b0, 1'b0);
      check("wrap_count", int'(free_count), 32);
    end

    // Reset mid-operation.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 6'(i), 1'b0, 1'b0);
    do_reset(1'b1, 1'b1, 1'b1);

    // Random traffic, keeping outstanding-since-checkpoint plus free within 64.
    for (int i = 0; i < 1500; i++) begin
      bit a, f, cs, rc;
      a  = ($urandom_range(0, 9) < 6);
      f  = ($urandom_range(0, 1) == 1) &&
           ((fl.size() + since.size() < 64) || (since.size() == 0));
      cs = ($urandom_range(0, 7) == 0);
      rc = ($urandom_range(0, 15) == 0);
      step(a, f, 6'($urandom_range(0, 63)), cs, rc);
    end
    check_outputs();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
